// File: rtl/tm_sch_pio_master.sv
// PIO master bridging single host transactions onto six region-selected memory responders.
// Optional `TM_PIO_TIMEOUT_EN adds a WAIT-state ack timeout that completes with an error code.
//
// state | meaning
// IDLE  | waiting for host_req; latches request and decodes region
// ISSUE | address/data/select driven; strobe fires on first clk_div=1 cycle
// WAIT  | waiting for selected memory's ack (or timeout when enabled)
// DONE  | one-cycle host_ack with rdata/err valid
module tm_sch_pio_master #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int REGION_LSB     = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_div,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [31:0] host_addr,
   input  logic [31:0] host_wdata,
   output logic        host_ack,
   output logic        host_err,
   output logic [31:0] host_rdata,
   output logic        host_busy,
   output logic [31:0] reg_addr,
   output logic [31:0] reg_din,
   output logic        reg_rd,
   output logic        reg_wr,
   output logic        reg_ms_queue_profile,
   output logic        reg_ms_wdrr_quantum,
   output logic        reg_ms_shaping_profile_cir,
   output logic        reg_ms_shaping_profile_eir,
   output logic        reg_ms_wdrr_sch_ctrl,
   output logic        reg_ms_fill_tb_dst,
   input  logic        queue_profile_mem_ack,
   input  logic        wdrr_quantum_mem_ack,
   input  logic        shaping_profile_cir_mem_ack,
   input  logic        shaping_profile_eir_mem_ack,
   input  logic        wdrr_sch_ctrl_mem_ack,
   input  logic        fill_tb_dst_mem_ack,
   input  logic [31:0] queue_profile_mem_rdata,
   input  logic [31:0] wdrr_quantum_mem_rdata,
   input  logic [31:0] shaping_profile_cir_mem_rdata,
   input  logic [31:0] shaping_profile_eir_mem_rdata,
   input  logic [31:0] wdrr_sch_ctrl_mem_rdata,
   input  logic [31:0] fill_tb_dst_mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  region_q, region_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        pend_q, pend_d;
`ifdef TM_PIO_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
`endif

   logic        sel_ack;
   logic [31:0] sel_rdata;
   logic        active;
   logic [3:0]  req_region;

   assign req_region = host_addr[REGION_LSB +: 4];

   always_comb begin
      sel_ack   = 1'b0;
      sel_rdata = '0;
      case (region_q)
         4'd0: begin sel_ack = queue_profile_mem_ack;       sel_rdata = queue_profile_mem_rdata;       end
         4'd1: begin sel_ack = wdrr_quantum_mem_ack;        sel_rdata = wdrr_quantum_mem_rdata;        end
         4'd2: begin sel_ack = shaping_profile_cir_mem_ack; sel_rdata = shaping_profile_cir_mem_rdata; end
         4'd3: begin sel_ack = shaping_profile_eir_mem_ack; sel_rdata = shaping_profile_eir_mem_rdata; end
         4'd4: begin sel_ack = wdrr_sch_ctrl_mem_ack;       sel_rdata = wdrr_sch_ctrl_mem_rdata;       end
         4'd5: begin sel_ack = fill_tb_dst_mem_ack;         sel_rdata = fill_tb_dst_mem_rdata;         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      region_d = region_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      pend_d   = pend_q;
`ifdef TM_PIO_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (host_req) begin
               we_d     = host_we;
               addr_d   = host_addr;
               wdata_d  = host_wdata;
               region_d = req_region;
               pend_d   = 1'b0;
               if (req_region > 4'd5) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = S_ISSUE;
                  err_d   = 1'b0;
               end
            end
         end
         S_ISSUE: begin
            if (clk_div) begin
               state_d = S_WAIT;
`ifdef TM_PIO_TIMEOUT_EN
               cnt_d   = '0;
`endif
               // A zero-wait responder acks alongside the strobe; remember it for WAIT.
               if (sel_ack) begin
                  pend_d  = 1'b1;
                  rdata_d = we_q ? 32'h0 : sel_rdata;
               end
            end
         end
         S_WAIT: begin
            if (pend_q) begin
               state_d = S_DONE;
            end else if (sel_ack) begin
               state_d = S_DONE;
               rdata_d = we_q ? 32'h0 : sel_rdata;
`ifdef TM_PIO_TIMEOUT_EN
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               rdata_d = 32'hDEAD_0000 | {28'h0, region_q};
            end else begin
               cnt_d = cnt_q + 8'd1;
`endif
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         region_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
`ifdef TM_PIO_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         region_q <= region_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
`ifdef TM_PIO_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign active     = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign host_ack   = (state_q == S_DONE);
   assign host_err   = host_ack && err_q;
   assign host_busy  = (state_q != S_IDLE);
   assign host_rdata = rdata_q;
   assign reg_addr   = active ? addr_q : 32'h0;
   assign reg_din    = active ? wdata_q : 32'h0;
   assign reg_wr     = (state_q == S_ISSUE) && clk_div && we_q;
   assign reg_rd     = (state_q == S_ISSUE) && clk_div && !we_q;

   assign reg_ms_queue_profile       = active && (region_q == 4'd0);
   assign reg_ms_wdrr_quantum        = active && (region_q == 4'd1);
   assign reg_ms_shaping_profile_cir = active && (region_q == 4'd2);
   assign reg_ms_shaping_profile_eir = active && (region_q == 4'd3);
   assign reg_ms_wdrr_sch_ctrl       = active && (region_q == 4'd4);
   assign reg_ms_fill_tb_dst         = active && (region_q == 4'd5);

endmodule

// File: tb/tb_tm_sch_pio_master.sv
// Self-checking bench for tm_sch_pio_master: directed vector table, reset/timeout sequences,
// and randomized transactions checked against a transaction-level latency/result model.
module tb_tm_sch_pio_master;
   logic        clk = 1'b0;
   logic        rst, clk_div, host_req, host_we;
   logic [31:0] host_addr, host_wdata;
   logic        host_ack, host_err, host_busy, reg_rd, reg_wr;
   logic [31:0] host_rdata, reg_addr, reg_din;
   logic        ms_qp, ms_wq, ms_cir, ms_eir, ms_ctrl, ms_fill;
   logic [5:0]  mack;
   logic [31:0] mrd [6];
   int          checks = 0;
   int          errors = 0;

`ifdef TM_PIO_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   always #5 clk = ~clk;

   tm_sch_pio_master #(.TIMEOUT_CYCLES(TO), .REGION_LSB(20)) dut (
      .clk(clk), .rst(rst), .clk_div(clk_div),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata), .host_busy(host_busy),
      .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr),
      .reg_ms_queue_profile(ms_qp), .reg_ms_wdrr_quantum(ms_wq),
      .reg_ms_shaping_profile_cir(ms_cir), .reg_ms_shaping_profile_eir(ms_eir),
      .reg_ms_wdrr_sch_ctrl(ms_ctrl), .reg_ms_fill_tb_dst(ms_fill),
      .queue_profile_mem_ack(mack[0]), .wdrr_quantum_mem_ack(mack[1]),
      .shaping_profile_cir_mem_ack(mack[2]), .shaping_profile_eir_mem_ack(mack[3]),
      .wdrr_sch_ctrl_mem_ack(mack[4]), .fill_tb_dst_mem_ack(mack[5]),
      .queue_profile_mem_rdata(mrd[0]), .wdrr_quantum_mem_rdata(mrd[1]),
      .shaping_profile_cir_mem_rdata(mrd[2]), .shaping_profile_eir_mem_rdata(mrd[3]),
      .wdrr_sch_ctrl_mem_rdata(mrd[4]), .fill_tb_dst_mem_rdata(mrd[5])
   );

   wire [5:0] ms = {ms_fill, ms_ctrl, ms_eir, ms_cir, ms_wq, ms_qp};

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] resp;
      int          d;
      int          mode;
      int          lat;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   vec_t tv [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] onehot(input int r);
      logic [5:0] v;
      v = '0;
      if (r < 6) v[r] = 1'b1;
      return v;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ctl"}, {21'h0, host_ack, host_err, host_busy, reg_rd, reg_wr, ms}, 32'h0);
      chk({tag, "_rdata"}, host_rdata, 32'h0);
      chk({tag, "_addr"}, reg_addr, 32'h0);
      chk({tag, "_din"}, reg_din, 32'h0);
   endtask

   // Entered at posedge+1 with the DUT idle. d<0 means the responder never acks.
   // mode: 0 clk_div always 1, 1 clk_div toggling (1 on even cycles), 2 random.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] resp, input int d, input int mode, input int budget,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int exp_lat);
      int r;
      bit mapped;
      int first_div;
      int strobes;
      r = int'(addr[23:20]);
      mapped = (r < 6);
      first_div = -1;
      strobes = 0;
      lat = -1; rd = '0; er = 1'b0;
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
      for (int n = 0; n < budget; n++) begin
         case (mode)
            0: clk_div = 1'b1;
            1: clk_div = (n % 2 == 0);
            default: clk_div = 1'($urandom_range(0, 1));
         endcase
         if (n >= 1 && first_div < 0 && clk_div) first_div = n;
         mack = 6'($urandom) & ~onehot(r);
         for (int k = 0; k < 6; k++) mrd[k] = $urandom;
         if (mapped) mrd[r] = resp;
         @(negedge clk);
         if (n == 0) chk("busy_idle", host_busy, 1'b0);
         if (host_ack) begin
            lat = n; rd = host_rdata; er = host_err;
            chk("done_ms", ms, 6'h0);
            chk("done_strobe", {reg_rd, reg_wr}, 2'b00);
            break;
         end
         if (n >= 1) chk("busy", host_busy, 1'b1);
         if (n >= 1 && mapped && (first_div < 0 || d < 0 || n <= first_div + d))
            chk("ms_sel", ms, onehot(r));
         if (reg_rd || reg_wr) begin
            strobes++;
            chk("strobe_mapped", mapped, 1'b1);
            chk("strobe_div", clk_div, 1'b1);
            chk("strobe_cycle", n, first_div);
            chk("strobe_kind", {reg_wr, reg_rd}, we ? 2'b10 : 2'b01);
            chk("strobe_addr", reg_addr, addr);
            chk("strobe_din", reg_din, wdata);
         end
         if (mapped && d >= 0 && first_div >= 0 && n == first_div + d) mack = mack | onehot(r);
         @(posedge clk); #1;
      end
      if (!mapped) exp_lat = 1;
      else if (d >= 0) exp_lat = first_div + ((d > 0) ? d : 1) + 1;
`ifdef TM_PIO_TIMEOUT_EN
      else exp_lat = first_div + TO + 1;
`else
      else exp_lat = -1;
`endif
      if (lat >= 0) begin
         chk("strobe_count", strobes, mapped ? 1 : 0);
         // host_req still high in the DONE cycle: it must not start a new transaction
         @(posedge clk); #1;
         host_req = 1'b0; mack = '0;
         @(negedge clk);
         chk("post_done_busy", host_busy, 1'b0);
         chk("post_done_ack", host_ack, 1'b0);
         @(posedge clk); #1;
      end else begin
         host_req = 1'b0; mack = '0;
      end
   endtask

   initial begin
      int lat, exp_lat;
      logic [31:0] rd;
      logic er;
      logic [31:0] a;
      logic        w;
      logic [31:0] wd, rp;
      int          dd, rg;

      tv[0] = '{1'b1, 32'h0020_0010, 32'h0000_1234, 32'h0,         2, 1, 5, 32'h0,         1'b0};
      tv[1] = '{1'b0, 32'h0050_0000, 32'h0,         32'h0000_0003, 0, 0, 3, 32'h0000_0003, 1'b0};
      tv[2] = '{1'b0, 32'h00A0_0000, 32'h0,         32'h5555_5555, 0, 0, 1, 32'h0,         1'b1};
      tv[3] = '{1'b0, 32'h0000_0100, 32'h0,         32'hAABB_CCDD, 1, 0, 3, 32'hAABB_CCDD, 1'b0};
      tv[4] = '{1'b1, 32'h0040_0004, 32'hCAFE_0001, 32'h7777_7777, 3, 0, 5, 32'h0,         1'b0};
      tv[5] = '{1'b0, 32'h0030_0008, 32'h0,         32'h1357_9BDF, 0, 1, 4, 32'h1357_9BDF, 1'b0};
      tv[6] = '{1'b1, 32'h00F0_0000, 32'h0000_FFFF, 32'h0,         0, 0, 1, 32'h0,         1'b1};
      tv[7] = '{1'b0, 32'h0010_0040, 32'h0,         32'h0BAD_F00D, 2, 0, 4, 32'h0BAD_F00D, 1'b0};

      rst = 1'b1; clk_div = 1'b0; host_req = 1'b0; host_we = 1'b0;
      host_addr = '0; host_wdata = '0; mack = '0;
      for (int k = 0; k < 6; k++) mrd[k] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].resp, tv[i].d, tv[i].mode, 50,
                 lat, rd, er, exp_lat);
         chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
         chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
         chk($sformatf("vec%0d_err", i), er, tv[i].er);
      end

      // Reset while waiting for a region-1 ack, then a late ack must be ignored.
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'h0010_0040; clk_div = 1'b1; mack = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_busy", host_busy, 1'b1);
      chk("wait_ms", ms, 6'b000010);
      @(posedge clk); #1;
      rst = 1'b1; host_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; mack = 6'b000010;
      @(negedge clk);
      chk_reset_vals("abort");
      @(posedge clk); #1;
      mack = '0;
      @(negedge clk);
      chk("abort_no_ack", host_ack, 1'b0);
      chk("abort_idle", host_busy, 1'b0);
      @(posedge clk); #1;
      run_txn(1'b0, 32'h0010_0044, 32'h0, 32'h2468_ACE0, 1, 0, 50, lat, rd, er, exp_lat);
      chk("recover_lat", lat, 3);
      chk("recover_rdata", rd, 32'h2468_ACE0);
      chk("recover_err", er, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rg = $urandom_range(0, 8);
         w  = 1'($urandom_range(0, 1));
         a  = (32'($urandom) & 32'hFF0F_FFFF) | (32'(rg) << 20);
         wd = $urandom;
         rp = $urandom;
         dd = $urandom_range(0, 3);
         run_txn(w, a, wd, rp, dd, 2, 200, lat, rd, er, exp_lat);
         chk("rnd_lat", lat, exp_lat);
         chk("rnd_rdata", rd, (rg >= 6 || w) ? 32'h0 : rp);
         chk("rnd_err", er, rg >= 6);
      end

      // Read of region 1 whose responder never answers.
`ifdef TM_PIO_TIMEOUT_EN
      run_txn(1'b0, 32'h0010_0000, 32'h0, 32'h0, -1, 0, 50, lat, rd, er, exp_lat);
      chk("timeout_lat", lat, 10);
      chk("timeout_rdata", rd, 32'hDEAD_0001);
      chk("timeout_err", er, 1'b1);
`else
      run_txn(1'b0, 32'h0010_0000, 32'h0, 32'h0, -1, 0, 1000, lat, rd, er, exp_lat);
      chk("no_timeout_ack", lat, -1);
      chk("no_timeout_busy", host_busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("final_reset");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tm_sch_pio_master.md
TM_SCH_PIO_MASTER -- requirements
Module: tm_sch_pio_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: cycles waited for mem_ack before error (1..255).
REQ-002 SHALL have parameter REGION_LSB, default 20: LSB of the 4-bit region field in host_addr.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, system clock; `RESET_SIG input 1, reset.
REQ-004 SHALL have clk_div input 1: PIO strobe enable; reg_rd/reg_wr are issued only in cycles where clk_div=1.
REQ-005 SHALL have host_req input 1, host_we input 1, host_addr input [`PIO_RANGE], host_wdata input [`PIO_RANGE]: host transaction request.
REQ-006 SHALL have host_ack output 1, host_err output 1, host_rdata output [`PIO_RANGE], host_busy output 1: host completion.
REQ-007 SHALL have reg_addr output [`PIO_RANGE], reg_din output [`PIO_RANGE], reg_rd output 1, reg_wr output 1: PIO bus to memory responders.
REQ-008 SHALL have reg_ms_queue_profile, reg_ms_wdrr_quantum, reg_ms_shaping_profile_cir, reg_ms_shaping_profile_eir, reg_ms_wdrr_sch_ctrl, reg_ms_fill_tb_dst, each output 1: one-hot memory selects, regions 0..5.
REQ-009 SHALL have six <mem>_mem_ack inputs 1 and six <mem>_mem_rdata inputs [`PIO_RANGE], same six memories: responder completions.

Function
REQ-010 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-011 IDLE: host_req=1 SHALL latch host_we/addr/wdata, set host_busy=1 next cycle; region = host_addr[REGION_LSB+3:REGION_LSB].
REQ-012 Region 6..15 (unmapped) SHALL go IDLE -> DONE directly with host_err=1, host_rdata=0, no PIO strobe, no reg_ms asserted.
REQ-013 ISSUE: reg_addr=latched addr, reg_din=latched wdata, selected reg_ms_* =1; SHALL stay in ISSUE until clk_div=1, then pulse reg_wr (we=1) or reg_rd (we=0) for exactly that one cycle and go to WAIT.
REQ-014 reg_ms_* SHALL remain asserted from ISSUE through the cycle mem_ack is sampled; SHALL deassert in DONE.
REQ-015 WAIT: only the selected memory's mem_ack counts; on ack SHALL capture its mem_rdata (read) or 0 (write) into host_rdata and go to DONE; acks from unselected memories ignored.
REQ-016 An ack arriving in the same cycle as the strobe SHALL be accepted (zero-wait responder).
REQ-017 DONE: host_ack=1 for exactly one cycle with host_rdata/host_err valid; host_rdata held until next transaction; host_busy=0 when back in IDLE.
REQ-018 host_req while host_busy=1 SHALL be ignored (not queued); host keeps host_req high until host_ack.
REQ-019 host_req sampled in the DONE cycle SHALL be ignored; a new transaction starts earliest the cycle after DONE.
REQ-020 reg_addr/reg_din SHALL be stable from ISSUE through WAIT; 0 in IDLE.
REQ-021 Minimum latency host_req -> host_ack: 3 cycles (IDLE, ISSUE with clk_div=1, WAIT with immediate ack, DONE ack).

Reset
REQ-022 Reset SHALL force IDLE and drive host_ack=0, host_err=0, host_rdata=0, host_busy=0, reg_rd=0, reg_wr=0, all reg_ms_*=0, reg_addr=0, reg_din=0, timeout counter=0.
REQ-023 Reset mid-transaction SHALL abort without host_ack; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-024 With TM_PIO_TIMEOUT_EN defined: 8-bit counter cleared on entering WAIT, increments each WAIT cycle; reaching TIMEOUT_CYCLES without ack SHALL go to DONE with host_err=1, host_rdata=32'hDEAD_0000 | region.
REQ-025 Without TM_PIO_TIMEOUT_EN: no counter; WAIT persists until ack; host_err only for unmapped regions.

Verification
REQ-026 Write region 2, addr 0x0020_0010, data 0x1234, clk_div toggling, ack 2 cycles after strobe -> one reg_wr pulse with clk_div=1, reg_ms_shaping_profile_cir=1 throughout, host_ack, host_err=0.
REQ-027 Read region 5, fill_tb_dst_mem_rdata=0x0000_0003 ack same cycle as reg_rd -> host_rdata=0x3 at host_ack, latency 3 cycles.
REQ-028 Access addr 0x00A0_0000 (region 10) -> host_ack 1 cycle after accept, host_err=1, host_rdata=0, no reg_rd/reg_wr, no reg_ms_*.
REQ-029 TM_PIO_TIMEOUT_EN, TIMEOUT_CYCLES=8, read region 1, no ack -> host_err=1, host_rdata=0xDEAD_0001 after 8 WAIT cycles; without macro -> no host_ack after 1000 cycles.
REQ-030 Reset asserted in WAIT, then wdrr_quantum_mem_ack pulsed -> no host_ack, all outputs at reset values, next transaction completes normally.
